// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter owner for the unpipelined MIPS32 core.
// Runs the IDLE/FETCH/EXEC/TRAP handshake, selects the next PC with fixed
// priority (trap > eret > jr > j > taken branch > pc+4) and keeps the
// EPC / cause / status (IE, EXL) registers.
module pc_sequencer #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter logic [31:0] EXC_VECTOR = 32'd12,
   parameter int unsigned CAUSE_W    = 5
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   // instruction memory port
   output logic               o_imem_req,
   output logic [31:0]        o_imem_addr,
   input  logic               i_imem_ready,
   // decode / execute handshake
   output logic               o_instr_valid,
   input  logic               i_exec_done,
   input  logic               i_j,
   input  logic               i_jr,
   input  logic               i_beq,
   input  logic               i_bne,
   input  logic               i_zero,
   input  logic [25:0]        i_imm26,
   input  logic [31:0]        i_rs,
   input  logic               i_eret,
   input  logic               i_ovf,
   input  logic               i_illegal,
   input  logic               i_irq,
   input  logic               i_ie_wr,
   input  logic               i_ie_data,
   // architectural state
   output logic [31:0]        o_pc,
   output logic [31:0]        o_epc,
   output logic [CAUSE_W-1:0] o_cause,
   output logic               o_exl,
   output logic               o_ie,
   output logic               o_trap
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_EXEC  = 2'd2,
      S_TRAP  = 2'd3
   } state_t;

   localparam logic [CAUSE_W-1:0] EXC_INT = CAUSE_W'(0);
   localparam logic [CAUSE_W-1:0] EXC_RI  = CAUSE_W'(10);
   localparam logic [CAUSE_W-1:0] EXC_OV  = CAUSE_W'(12);

   state_t               r_state;
   state_t               w_state_next;

   logic [31:0]          r_pc;
   logic [31:0]          r_epc;
   logic [CAUSE_W-1:0]   r_cause;
   logic                 r_exl;
   logic                 r_ie;
   // trap information latched in EXEC, applied in TRAP
   logic [31:0]          r_cap_epc;
   logic [CAUSE_W-1:0]   r_cap_code;

   logic [31:0]          w_pc4;
   logic [31:0]          w_br_off;
   logic [31:0]          w_br_target;
   logic [31:0]          w_j_target;
   logic [31:0]          w_eret_target;
   logic [31:0]          w_next_pc;
   logic                 w_taken;
   logic                 w_commit;
   logic                 w_sync_exc;
   logic                 w_irq_take;
   logic                 w_trap;
   logic [CAUSE_W-1:0]   w_trap_code;
   logic [31:0]          w_trap_epc;

   // Candidate targets. Everything except jr is word aligned.
   assign w_pc4         = {r_pc[31:2] + 30'd1, 2'b00};
   assign w_br_off      = {{14{i_imm26[15]}}, i_imm26[15:0], 2'b00};
   assign w_br_target   = w_pc4 + w_br_off;
   assign w_j_target    = {w_pc4[31:28], i_imm26, 2'b00};
   assign w_eret_target = {r_epc[31:2], 2'b00};
   assign w_taken       = (i_beq & i_zero) | (i_bne & ~i_zero);

   // Control inputs only matter when the execute stage signals completion.
   assign w_commit   = (r_state == S_EXEC) && i_exec_done;
   assign w_sync_exc = i_illegal | i_ovf;
   // Interrupts are masked by IE and blocked while already in a handler.
   assign w_irq_take = i_irq & r_ie & ~r_exl;
   assign w_trap     = w_commit & (w_sync_exc | w_irq_take);

   // Next PC for a non-trapping instruction, by fixed priority.
   always_comb begin
      w_next_pc = w_pc4;
      if (i_eret) begin
         w_next_pc = w_eret_target;
      end else if (i_jr) begin
         w_next_pc = i_rs;
      end else if (i_j) begin
         w_next_pc = w_j_target;
      end else if (w_taken) begin
         w_next_pc = w_br_target;
      end
   end

   // Exception code and return address: sync faults restart the faulting
   // instruction, interrupts resume after the completed one.
   always_comb begin
      w_trap_code = EXC_INT;
      w_trap_epc  = w_next_pc;
      if (i_illegal) begin
         w_trap_code = EXC_RI;
         w_trap_epc  = r_pc;
      end else if (i_ovf) begin
         w_trap_code = EXC_OV;
         w_trap_epc  = r_pc;
      end
   end

   // State register.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic and state-decoded handshake outputs.
   always_comb begin
      w_state_next  = r_state;
      o_imem_req    = 1'b0;
      o_instr_valid = 1'b0;
      o_trap        = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_state_next = S_FETCH;
         end
         S_FETCH: begin
            o_imem_req = 1'b1;
            if (i_imem_ready) begin
               w_state_next = S_EXEC;
            end
         end
         S_EXEC: begin
            o_instr_valid = 1'b1;
            if (i_exec_done) begin
               w_state_next = w_trap ? S_TRAP : S_FETCH;
            end
         end
         S_TRAP: begin
            o_trap       = 1'b1;
            w_state_next = S_FETCH;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   // Architectural registers: single update point for pc and status.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_pc       <= {RESET_PC[31:2], 2'b00};
         r_epc      <= 32'd0;
         r_cause    <= '0;
         r_exl      <= 1'b0;
         r_ie       <= 1'b0;
         r_cap_epc  <= 32'd0;
         r_cap_code <= '0;
      end else begin
         if (w_trap) begin
            r_cap_epc  <= w_trap_epc;
            r_cap_code <= w_trap_code;
         end

         if (r_state == S_TRAP) begin
            r_pc    <= {EXC_VECTOR[31:2], 2'b00};
            // a nested sync fault keeps the original return address
            if (!r_exl) begin
               r_epc <= r_cap_epc;
            end
            r_exl   <= 1'b1;
            r_cause <= r_cap_code;
         end else if (w_commit && !w_trap) begin
            r_pc <= w_next_pc;
            if (i_eret) begin
               r_exl <= 1'b0;
            end
         end

         // IE is software-writable in every state, including TRAP.
         if (i_ie_wr) begin
            r_ie <= i_ie_data;
         end
      end
   end

   assign o_pc        = r_pc;
   assign o_imem_addr = r_pc;
   assign o_epc       = r_epc;
   assign o_cause     = r_cause;
   assign o_exl       = r_exl;
   assign o_ie        = r_ie;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus a randomized
// instruction stream checked against an architectural reference model.
`timescale 1ns/1ps
module tb_pc_sequencer;

   logic        i_clk = 1'b0;
   logic        i_rst_n;
   logic        o_imem_req;
   logic [31:0] o_imem_addr;
   logic        i_imem_ready;
   logic        o_instr_valid;
   logic        i_exec_done;
   logic        i_j, i_jr, i_beq, i_bne, i_zero;
   logic [25:0] i_imm26;
   logic [31:0] i_rs;
   logic        i_eret, i_ovf, i_illegal, i_irq, i_ie_wr, i_ie_data;
   logic [31:0] o_pc;
   logic [31:0] o_epc;
   logic [4:0]  o_cause;
   logic        o_exl, o_ie, o_trap;

   always #5 i_clk = ~i_clk;

   pc_sequencer #(
      .RESET_PC   (32'h0000_0000),
      .EXC_VECTOR (32'd12),
      .CAUSE_W    (5)
   ) dut (
      .i_clk         (i_clk),
      .i_rst_n       (i_rst_n),
      .o_imem_req    (o_imem_req),
      .o_imem_addr   (o_imem_addr),
      .i_imem_ready  (i_imem_ready),
      .o_instr_valid (o_instr_valid),
      .i_exec_done   (i_exec_done),
      .i_j           (i_j),
      .i_jr          (i_jr),
      .i_beq         (i_beq),
      .i_bne         (i_bne),
      .i_zero        (i_zero),
      .i_imm26       (i_imm26),
      .i_rs          (i_rs),
      .i_eret        (i_eret),
      .i_ovf         (i_ovf),
      .i_illegal     (i_illegal),
      .i_irq         (i_irq),
      .i_ie_wr       (i_ie_wr),
      .i_ie_data     (i_ie_data),
      .o_pc          (o_pc),
      .o_epc         (o_epc),
      .o_cause       (o_cause),
      .o_exl         (o_exl),
      .o_ie          (o_ie),
      .o_trap        (o_trap)
   );

   typedef struct packed {
      logic        j;
      logic        jr;
      logic        beq;
      logic        bne;
      logic        zero;
      logic        eret;
      logic        ovf;
      logic        illegal;
      logic        irq;
      logic        ie_wr;
      logic        ie_data;
      logic [25:0] imm26;
      logic [31:0] rs;
   } ctrl_t;

   int n_cmp = 0;
   int n_bad = 0;

   // architectural reference state
   logic [31:0] m_pc, m_epc;
   logic [4:0]  m_cause;
   logic        m_exl, m_ie;

   logic obs_trap;
   logic exp_trap;

   task automatic clear_ctrl();
      i_exec_done = 0; i_j = 0; i_jr = 0; i_beq = 0; i_bne = 0; i_zero = 0;
      i_imm26 = '0; i_rs = '0; i_eret = 0; i_ovf = 0; i_illegal = 0;
      i_irq = 0; i_ie_wr = 0; i_ie_data = 0;
   endtask

   task automatic model_reset();
      m_pc = 32'd0; m_epc = 32'd0; m_cause = 5'd0; m_exl = 0; m_ie = 0;
   endtask

   // Architectural effect of one completed instruction (IE write excluded).
   task automatic model_step(input ctrl_t c, output logic trap);
      logic [31:0] pc4, nxt;
      int          off;
      pc4 = (m_pc & 32'hFFFF_FFFC) + 32'd4;
      off = 4 * int'($signed(c.imm26[15:0]));
      if (c.eret)                                    nxt = m_epc & 32'hFFFF_FFFC;
      else if (c.jr)                                 nxt = c.rs;
      else if (c.j)                                  nxt = (pc4 & 32'hF000_0000) | (32'(c.imm26) << 2);
      else if ((c.beq && c.zero) || (c.bne && !c.zero)) nxt = pc4 + 32'(off);
      else                                           nxt = pc4;
      trap = 1'b1;
      if (c.illegal) begin
         if (!m_exl) m_epc = m_pc;
         m_cause = 5'd10;
      end else if (c.ovf) begin
         if (!m_exl) m_epc = m_pc;
         m_cause = 5'd12;
      end else if (c.irq && m_ie && !m_exl) begin
         m_epc   = nxt;
         m_cause = 5'd0;
      end else begin
         trap = 1'b0;
      end
      if (trap) begin
         m_exl = 1'b1;
         m_pc  = 32'd12;
      end else begin
         if (c.eret) m_exl = 1'b0;
         m_pc = nxt;
      end
   endtask

   task automatic do_reset();
      clear_ctrl();
      i_imem_ready = 0;
      @(negedge i_clk); i_rst_n = 0;
      @(negedge i_clk); i_rst_n = 1;
      model_reset();
   endtask

   // Run one instruction through FETCH (with stall cycles) and EXEC.
   // Returns at a negedge with the sequencer back in FETCH.
   task automatic exec_instr(input ctrl_t c, input int stall);
      int n;
      n = 0;
      while (!o_imem_req && n < 20) begin @(negedge i_clk); n++; end
      if (!o_imem_req) begin
         n_cmp++; n_bad++;
         $display("FAIL fetch_wait: o_imem_req=%0b required 1 within 20 cycles", o_imem_req);
      end
      i_imem_ready = 0;
      repeat (stall) @(negedge i_clk);
      i_imem_ready = 1;
      @(negedge i_clk);
      i_imem_ready = 0;
      n = 0;
      while (!o_instr_valid && n < 20) begin @(negedge i_clk); n++; end
      if (!o_instr_valid) begin
         n_cmp++; n_bad++;
         $display("FAIL exec_wait: o_instr_valid=%0b required 1 within 20 cycles", o_instr_valid);
      end
      model_step(c, exp_trap);
      i_exec_done = 1; i_j = c.j; i_jr = c.jr; i_beq = c.beq; i_bne = c.bne;
      i_zero = c.zero; i_imm26 = c.imm26; i_rs = c.rs; i_eret = c.eret;
      i_ovf = c.ovf; i_illegal = c.illegal; i_irq = c.irq;
      if (!exp_trap && c.ie_wr) begin
         i_ie_wr = 1; i_ie_data = c.ie_data; m_ie = c.ie_data;
      end
      @(negedge i_clk);
      clear_ctrl();
      obs_trap = o_trap;
      if (exp_trap) begin
         if (c.ie_wr) begin
            i_ie_wr = 1; i_ie_data = c.ie_data; m_ie = c.ie_data;
         end
         @(negedge i_clk);
         clear_ctrl();
      end
   endtask

   function automatic ctrl_t jr_to(input logic [31:0] a);
      ctrl_t c;
      c = '0; c.jr = 1; c.rs = a;
      return c;
   endfunction

   task automatic test_reset();
      do_reset();
      n_cmp++; if (o_pc !== 32'd0 || o_imem_addr !== 32'd0) begin n_bad++; $display("FAIL reset_pc: pc=%h addr=%h required 0", o_pc, o_imem_addr); end
      n_cmp++; if ({o_epc, o_cause, o_exl, o_ie} !== 39'd0) begin n_bad++; $display("FAIL reset_regs: epc=%h cause=%0d exl=%0b ie=%0b required 0", o_epc, o_cause, o_exl, o_ie); end
      n_cmp++; if ({o_imem_req, o_instr_valid, o_trap} !== 3'b000) begin n_bad++; $display("FAIL reset_idle: req/valid/trap=%b required 000", {o_imem_req, o_instr_valid, o_trap}); end
   endtask

   // ready and done held high: FETCH/EXEC alternate and pc steps by 4.
   task automatic test_sequential();
      logic [31:0] e_pc;
      clear_ctrl();
      @(negedge i_clk); i_rst_n = 0; i_imem_ready = 1; i_exec_done = 1;
      @(negedge i_clk);
      for (int k = 0; k < 9; k++) begin
         e_pc = (k == 0) ? 32'd0 : 32'((k - 1) / 2) * 32'd4;
         n_cmp++; if (o_pc !== e_pc) begin n_bad++; $display("FAIL seq_pc[%0d]: pc=%h required %h", k, o_pc, e_pc); end
         n_cmp++; if (o_imem_req !== (k % 2 == 1)) begin n_bad++; $display("FAIL seq_req[%0d]: req=%0b required %0b", k, o_imem_req, (k % 2 == 1)); end
         i_rst_n = 1;
         @(negedge i_clk);
      end
      do_reset();
   endtask

   task automatic test_branch();
      ctrl_t c;
      exec_instr(jr_to(32'h100), 0);
      c = '0; c.beq = 1; c.zero = 1; c.imm26 = 26'h000FFFE;
      exec_instr(c, 1);
      n_cmp++; if (o_pc !== 32'h0FC) begin n_bad++; $display("FAIL beq_taken: pc=%h required 000000fc", o_pc); end
      exec_instr(jr_to(32'h100), 0);
      c.zero = 0;
      exec_instr(c, 0);
      n_cmp++; if (o_pc !== 32'h104) begin n_bad++; $display("FAIL beq_not_taken: pc=%h required 00000104", o_pc); end
      c = '0; c.bne = 1; c.zero = 0; c.imm26 = 26'h0000002;
      exec_instr(c, 2);
      n_cmp++; if (o_pc !== 32'h110) begin n_bad++; $display("FAIL bne_taken: pc=%h required 00000110", o_pc); end
   endtask

   task automatic test_jump();
      ctrl_t c;
      exec_instr(jr_to(32'h1000_0040), 0);
      c = '0; c.j = 1; c.imm26 = 26'h0000010;
      exec_instr(c, 0);
      n_cmp++; if (o_pc !== 32'h1000_0040) begin n_bad++; $display("FAIL j_target: pc=%h required 10000040", o_pc); end
      exec_instr(jr_to(32'h2003), 0);
      n_cmp++; if (o_pc !== 32'h2003) begin n_bad++; $display("FAIL jr_verbatim: pc=%h required 00002003", o_pc); end
      exec_instr('0, 0);
      n_cmp++; if (o_pc !== 32'h2004) begin n_bad++; $display("FAIL pc4_align: pc=%h required 00002004", o_pc); end
      exec_instr(jr_to(32'hFFFF_FFFC), 0);
      exec_instr('0, 0);
      n_cmp++; if (o_pc !== 32'h0) begin n_bad++; $display("FAIL pc4_wrap: pc=%h required 00000000", o_pc); end
   endtask

   task automatic test_exceptions();
      ctrl_t c;
      exec_instr(jr_to(32'h200), 0);
      c = '0; c.ovf = 1;
      exec_instr(c, 0);
      n_cmp++; if (obs_trap !== 1'b1) begin n_bad++; $display("FAIL ovf_trap: trap=%0b required 1", obs_trap); end
      n_cmp++; if (o_epc !== 32'h200 || o_cause !== 5'd12 || o_exl !== 1'b1 || o_pc !== 32'd12) begin
         n_bad++; $display("FAIL ovf_state: epc=%h cause=%0d exl=%0b pc=%h required 200/12/1/c", o_epc, o_cause, o_exl, o_pc); end
      exec_instr(jr_to(32'h10), 0);
      c = '0; c.illegal = 1; c.ovf = 1; c.eret = 1;
      exec_instr(c, 0);
      n_cmp++; if (obs_trap !== 1'b1 || o_cause !== 5'd10 || o_epc !== 32'h200 || o_pc !== 32'd12) begin
         n_bad++; $display("FAIL nested_illegal: trap=%0b cause=%0d epc=%h pc=%h required 1/10/200/c", obs_trap, o_cause, o_epc, o_pc); end
      c = '0; c.eret = 1;
      exec_instr(c, 0);
      n_cmp++; if (o_pc !== 32'h200 || o_exl !== 1'b0 || obs_trap !== 1'b0) begin
         n_bad++; $display("FAIL eret: pc=%h exl=%0b trap=%0b required 200/0/0", o_pc, o_exl, obs_trap); end
   endtask

   task automatic test_irq();
      ctrl_t c;
      c = '0; c.ie_wr = 1; c.ie_data = 1;
      exec_instr(c, 0);
      n_cmp++; if (o_ie !== 1'b1) begin n_bad++; $display("FAIL ie_write: ie=%0b required 1", o_ie); end
      exec_instr(jr_to(32'h300), 0);
      c = '0; c.irq = 1;
      exec_instr(c, 0);
      n_cmp++; if (obs_trap !== 1'b1 || o_epc !== 32'h304 || o_cause !== 5'd0 || o_pc !== 32'd12 || o_exl !== 1'b1) begin
         n_bad++; $display("FAIL irq_taken: trap=%0b epc=%h cause=%0d pc=%h exl=%0b required 1/304/0/c/1", obs_trap, o_epc, o_cause, o_pc, o_exl); end
      exec_instr(c, 0);
      n_cmp++; if (obs_trap !== 1'b0 || o_pc !== 32'd16) begin n_bad++; $display("FAIL irq_masked_exl: trap=%0b pc=%h required 0/10", obs_trap, o_pc); end
      c = '0; c.eret = 1; c.ie_wr = 1; c.ie_data = 0;
      exec_instr(c, 0);
      c = '0; c.irq = 1;
      exec_instr(c, 0);
      n_cmp++; if (obs_trap !== 1'b0 || o_pc !== 32'h308 || o_ie !== 1'b0) begin n_bad++; $display("FAIL irq_masked_ie: trap=%0b pc=%h ie=%0b required 0/308/0", obs_trap, o_pc, o_ie); end
      c = '0; c.ie_wr = 1; c.ie_data = 1;
      exec_instr(c, 0);
      c = '0; c.irq = 1; c.ie_wr = 1; c.ie_data = 0;
      exec_instr(c, 0);
      n_cmp++; if (obs_trap !== 1'b1 || o_ie !== 1'b0 || o_epc !== 32'h310) begin n_bad++; $display("FAIL ie_wr_in_trap: trap=%0b ie=%0b epc=%h required 1/0/310", obs_trap, o_ie, o_epc); end
   endtask

   // Reset abandoning an EXEC (scenario 0) and a stalled FETCH (scenario 1).
   task automatic test_reset_mid();
      ctrl_t c;
      for (int s = 0; s < 2; s++) begin
         do_reset();
         c = '0; c.ovf = 1; c.ie_wr = 1; c.ie_data = 1;
         exec_instr(c, 0);
         exec_instr(jr_to(32'h400), 0);
         if (s == 0) begin
            i_imem_ready = 1;
            @(negedge i_clk);
            i_imem_ready = 0;
            n_cmp++; if (o_instr_valid !== 1'b1 || o_pc !== 32'h400) begin n_bad++; $display("FAIL rst%0d_pre: valid=%0b pc=%h required 1/400", s, o_instr_valid, o_pc); end
            i_exec_done = 1; i_ovf = 1;
         end else begin
            repeat (5) @(negedge i_clk);
            n_cmp++; if (o_imem_req !== 1'b1 || o_pc !== 32'h400) begin n_bad++; $display("FAIL rst%0d_pre: req=%0b pc=%h required 1/400", s, o_imem_req, o_pc); end
            i_imem_ready = 1;
         end
         i_rst_n = 0;
         @(negedge i_clk);
         i_rst_n = 1; i_imem_ready = 0; clear_ctrl();
         n_cmp++; if (o_pc !== 32'd0 || o_exl !== 1'b0 || o_ie !== 1'b0 || o_epc !== 32'd0 || o_cause !== 5'd0) begin
            n_bad++; $display("FAIL rst%0d_regs: pc=%h exl=%0b ie=%0b epc=%h cause=%0d required all 0", s, o_pc, o_exl, o_ie, o_epc, o_cause); end
         n_cmp++; if ({o_imem_req, o_instr_valid, o_trap} !== 3'b000) begin n_bad++; $display("FAIL rst%0d_idle: req/valid/trap=%b required 000", s, {o_imem_req, o_instr_valid, o_trap}); end
         @(negedge i_clk);
         n_cmp++; if (o_imem_req !== 1'b1) begin n_bad++; $display("FAIL rst%0d_fetch: req=%0b required 1", s, o_imem_req); end
         model_reset();
      end
   endtask

   task automatic test_random();
      ctrl_t c;
      for (int t = 0; t < 150; t++) begin
         c = '0;
         c.j       = ($urandom_range(0, 3) == 0);
         c.jr      = ($urandom_range(0, 5) == 0);
         c.beq     = ($urandom_range(0, 2) == 0);
         c.bne     = ($urandom_range(0, 2) == 0);
         c.zero    = $urandom_range(0, 1) == 1;
         c.eret    = ($urandom_range(0, 5) == 0);
         c.ovf     = ($urandom_range(0, 9) == 0);
         c.illegal = ($urandom_range(0, 11) == 0);
         c.irq     = ($urandom_range(0, 2) == 0);
         c.ie_wr   = ($urandom_range(0, 5) == 0);
         c.ie_data = $urandom_range(0, 1) == 1;
         c.imm26   = 26'($urandom);
         c.rs      = $urandom;
         exec_instr(c, $urandom_range(0, 2));
         $display("txn %0d: pc=%h epc=%h cause=%0d exl=%0b ie=%0b trap=%0b", t, o_pc, o_epc, o_cause, o_exl, o_ie, obs_trap);
         n_cmp++; if (o_pc !== m_pc) begin n_bad++; $display("FAIL rnd_pc[%0d]: pc=%h required %h", t, o_pc, m_pc); end
         n_cmp++; if (o_epc !== m_epc || o_cause !== m_cause) begin n_bad++; $display("FAIL rnd_exc[%0d]: epc=%h cause=%0d required %h/%0d", t, o_epc, o_cause, m_epc, m_cause); end
         n_cmp++; if (o_exl !== m_exl || o_ie !== m_ie || obs_trap !== exp_trap) begin
            n_bad++; $display("FAIL rnd_status[%0d]: exl=%0b ie=%0b trap=%0b required %0b/%0b/%0b", t, o_exl, o_ie, obs_trap, m_exl, m_ie, exp_trap); end
      end
   endtask

   initial begin
      i_rst_n = 0;
      i_imem_ready = 0;
      clear_ctrl();
      model_reset();
      repeat (2) @(negedge i_clk);
      test_reset();
      test_sequential();
      test_branch();
      test_jump();
      test_exceptions();
      test_irq();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
